// File: rtl/dmem_stage_mc_pkg.sv
// Shared definitions for the data-memory stage: FSM encodings and default geometry.
package dmem_stage_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1
  } dmem_state_t;

  localparam int DMEM_DATA_W  = 16;
  localparam int DMEM_ADDR_W  = 16;
  localparam int DMEM_MEM_AW  = 10;
  localparam int DMEM_LATENCY = 4;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W data array: asynchronous read port, synchronous write port, no reset.
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [MEM_AW-1:0] ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**MEM_AW];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_stage_mc.sv
// MEM-stage data memory with configurable access latency; freezes the upstream
// pipeline with a combinational stall until the latched access completes.
module dmem_stage_mc
  import dmem_stage_mc_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int MEM_AW  = DMEM_MEM_AW,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              stall,
  output logic              busy,
  output logic              misalign,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  // Request/stall contract: a request (mem_read|mem_write) is held by the pipeline
  // while stall=1 and is consumed in the first cycle it is seen with stall=0.
  // rdata is meaningful only while rdata_valid=1.
  logic              req;
  logic [MEM_AW-1:0] idx;
  logic              done;
  logic              unused_addr_hi;

  dmem_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_read;
  logic              lat_write;
  logic              lat_mis;
  logic [MEM_AW-1:0] lat_idx;
  logic [DATA_W-1:0] lat_wdata;

  logic              arr_we;
  logic [MEM_AW-1:0] arr_idx;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign req            = mem_read | mem_write;
  assign idx            = addr[MEM_AW:1];
  assign unused_addr_hi = ^addr[ADDR_W-1:MEM_AW+1];
  assign done           = (state == ST_WAIT) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_mis   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else if (LATENCY > 1) begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_read  <= mem_read & ~mem_write;
            lat_write <= mem_write;
            lat_mis   <= addr[0];
            lat_idx   <= idx;
            lat_wdata <= wdata;
            cnt       <= CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall       = 1'b0;
    rdata_valid = 1'b0;
    misalign    = 1'b0;
    arr_we      = 1'b0;
    arr_idx     = lat_idx;
    arr_wdata   = lat_wdata;
    if (LATENCY == 1) begin
      arr_idx     = idx;
      arr_wdata   = wdata;
      arr_we      = mem_write;
      rdata_valid = mem_read & ~mem_write;
      misalign    = req & addr[0];
    end else if (state == ST_IDLE) begin
      stall = req;
    end else if (!done) begin
      stall = 1'b1;
    end else begin
      rdata_valid = lat_read;
      misalign    = lat_mis;
      arr_we      = lat_write;
    end
    // Reset drops everything at once, including a write that would commit this edge.
    if (rst) begin
      stall       = 1'b0;
      rdata_valid = 1'b0;
      misalign    = 1'b0;
      arr_we      = 1'b0;
    end
  end

  assign rdata     = rdata_valid ? arr_rdata : '0;
  assign busy      = (state == ST_WAIT);
  assign state_dbg = state;

  dmem_array #(
    .DATA_W(DATA_W),
    .MEM_AW(MEM_AW)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .widx (arr_idx),
    .wdata(arr_wdata),
    .ridx (arr_idx),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_dmem_stage_mc.sv
// Directed bench for dmem_stage_mc: a LATENCY=4 instance and a LATENCY=1 instance.
module tb_dmem_stage_mc;
  import dmem_stage_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        rd4 = 1'b0, wr4 = 1'b0;
  logic [15:0] addr4 = '0, wdata4 = '0, rdata4;
  logic        rv4, stall4, busy4, mis4;
  logic [1:0]  st4;

  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [15:0] addr1 = '0, wdata1 = '0, rdata1;
  logic        rv1, stall1, busy1, mis1;
  logic [1:0]  st1;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model [1024];

  dmem_stage_mc #(.DATA_W(16), .ADDR_W(16), .MEM_AW(10), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .mem_read(rd4), .mem_write(wr4), .addr(addr4),
    .wdata(wdata4), .rdata(rdata4), .rdata_valid(rv4), .stall(stall4),
    .busy(busy4), .misalign(mis4), .state_dbg(st4)
  );

  dmem_stage_mc #(.DATA_W(16), .ADDR_W(16), .MEM_AW(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .addr(addr1),
    .wdata(wdata1), .rdata(rdata1), .rdata_valid(rv1), .stall(stall1),
    .busy(busy1), .misalign(mis1), .state_dbg(st1)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full LATENCY=4 access starting at posedge+1; returns at posedge+1 of the
  // cycle after completion. With scramble set, inputs are garbled while in WAIT.
  task automatic access4(input string tag, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] wd,
                         input logic scramble, input logic exp_mis);
    logic exp_rv;
    logic [9:0] mi;
    exp_rv = rd & ~wr;
    mi = a[10:1];
    rd4 = rd; wr4 = wr; addr4 = a; wdata4 = wd;
    if (exp_rv) exp_q.push_back(model[mi]);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check({tag, "_stall"}, 32'(stall4), (c < 3) ? 32'd1 : 32'd0);
      check({tag, "_busy"},  32'(busy4),  (c > 0) ? 32'd1 : 32'd0);
      check({tag, "_mis"},   32'(mis4),   (c == 3) ? 32'(exp_mis) : 32'd0);
      check({tag, "_rv"},    32'(rv4),    (c == 3) ? 32'(exp_rv) : 32'd0);
      if (c == 3 && exp_rv) check({tag, "_rdata"}, 32'(rdata4), 32'(exp_q.pop_front()));
      @(posedge clk); #1;
      if (scramble && c < 3) begin
        addr4  = 16'($urandom_range(0, 65535));
        wdata4 = 16'($urandom_range(0, 65535));
        wr4    = ~wr4;
      end
    end
    if (wr) model[mi] = wd;
    rd4 = 1'b0; wr4 = 1'b0; addr4 = '0; wdata4 = '0;
  endtask

  task automatic cycle1(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd);
    rd1 = rd; wr1 = wr; addr1 = a; wdata1 = wd;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_stall4", 32'(stall4), 0);
    check("rst_rv4",    32'(rv4),    0);
    check("rst_rdata4", 32'(rdata4), 0);
    check("rst_busy4",  32'(busy4),  0);
    check("rst_mis4",   32'(mis4),   0);
    check("rst_state4", 32'(st4),    32'(ST_IDLE));
    check("rst_stall1", 32'(stall1), 0);
    check("rst_rv1",    32'(rv1),    0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Store then back-to-back load
    access4("sw_beef", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0);
    check("arr8_beef", 32'(u_dut4.u_array.mem[8]), 32'h0000BEEF);
    access4("lw_beef", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);

    // Inputs garbled during WAIT must not matter
    access4("sw_scr", 1'b0, 1'b1, 16'h0040, 16'hC0DE, 1'b1, 1'b0);
    access4("lw_scr", 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0);

    // Reset mid-store discards the write
    access4("sw_5555", 1'b0, 1'b1, 16'h0020, 16'h5555, 1'b0, 1'b0);
    rd4 = 1'b0; wr4 = 1'b1; addr4 = 16'h0020; wdata4 = 16'h1234;
    @(negedge clk);
    check("abort_c0_stall", 32'(stall4), 1);
    @(posedge clk); #1;
    check("abort_c1_busy", 32'(busy4), 1);
    rst = 1'b1; wr4 = 1'b0; addr4 = '0; wdata4 = '0;
    #1;
    check("abort_stall", 32'(stall4), 0);
    check("abort_busy",  32'(busy4),  0);
    check("abort_state", 32'(st4),    32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("arr16_kept", 32'(u_dut4.u_array.mem[16]), 32'h00005555);
    access4("lw_5555", 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);

    // Misaligned load, simultaneous SW+LW, index aliasing
    access4("lw_mis", 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b1);
    access4("swlw",   1'b1, 1'b1, 16'h0030, 16'hA5A5, 1'b0, 1'b0);
    access4("lw_a5",  1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0);
    access4("lw_alias", 1'b1, 1'b0, 16'h0810, 16'h0000, 1'b0, 1'b0);

    // LATENCY=1 stream: write then read each location in consecutive cycles
    for (int i = 0; i < 4; i++) begin
      logic [15:0] a, d;
      a = 16'h0100 + 16'(2 * i);
      d = 16'h1000 * 16'(i + 1) + 16'(i);
      cycle1(1'b0, 1'b1, a, d);
      @(negedge clk);
      check("l1_sw_stall", 32'(stall1), 0);
      check("l1_sw_rv",    32'(rv1),    0);
      @(posedge clk); #1;
      cycle1(1'b1, 1'b0, a, 16'h0000);
      @(negedge clk);
      check("l1_lw_stall", 32'(stall1), 0);
      check("l1_lw_rv",    32'(rv1),    1);
      check("l1_lw_rdata", 32'(rdata1), 32'(d));
      @(posedge clk); #1;
    end
    // Same-cycle combinational read follows addr with no clock edge
    cycle1(1'b1, 1'b0, 16'h0100, 16'h0000);
    #1 check("l1_comb_a0", 32'(rdata1), 32'h00001000);
    addr1 = 16'h0106;
    #1 check("l1_comb_a3", 32'(rdata1), 32'h00004003);
    addr1 = 16'h0103;
    #1 check("l1_mis", 32'(mis1), 1);
    check("l1_mis_rdata", 32'(rdata1), 32'h00002001);
    cycle1(1'b1, 1'b1, 16'h0102, 16'h7777);
    #1 check("l1_swlw_rv", 32'(rv1), 0);
    check("l1_swlw_stall", 32'(stall1), 0);
    @(posedge clk); #1;
    cycle1(1'b1, 1'b0, 16'h0102, 16'h0000);
    @(negedge clk);
    check("l1_swlw_rdata", 32'(rdata1), 32'h00007777);
    check("l1_busy", 32'(busy1), 0);
    @(posedge clk); #1;
    cycle1(1'b0, 1'b0, 16'h0000, 16'h0000);

    // Final report
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
